// File: rtl/ps2_kb_pkg.sv
// Shared PS/2 Set-2 keyboard definitions: prefix bytes, decoder states, event entry.
// Optional ASCII translation (entry field + lookup) is present only when KB_ASCII_EN is defined.
package ps2_kb_pkg;

    localparam logic [7:0] KB_PFX_EXT = 8'hE0;
    localparam logic [7:0] KB_PFX_BRK = 8'hF0;
    localparam logic [7:0] KB_BAT_OK  = 8'hAA;
    localparam logic [7:0] KB_ACK     = 8'hFA;
    localparam logic [7:0] KB_ERR_00  = 8'h00;
    localparam logic [7:0] KB_ERR_FF  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } kb_state_e;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
`ifdef KB_ASCII_EN
        logic [7:0] ascii;
`endif
    } kb_event_t;

`ifdef KB_ASCII_EN
    // Letters honour shift XOR caps; digits only honour shift (US layout symbols).
    function automatic logic [7:0] kb_ascii_lookup(input logic [7:0] code,
                                                   input logic       shift,
                                                   input logic       caps);
        logic [7:0] lc;
        logic [7:0] res;
        lc  = '0;
        res = '0;
        case (code)
            8'h1C: lc = 8'h61; 8'h32: lc = 8'h62; 8'h21: lc = 8'h63; 8'h23: lc = 8'h64;
            8'h24: lc = 8'h65; 8'h2B: lc = 8'h66; 8'h34: lc = 8'h67; 8'h33: lc = 8'h68;
            8'h43: lc = 8'h69; 8'h3B: lc = 8'h6A; 8'h42: lc = 8'h6B; 8'h4B: lc = 8'h6C;
            8'h3A: lc = 8'h6D; 8'h31: lc = 8'h6E; 8'h44: lc = 8'h6F; 8'h4D: lc = 8'h70;
            8'h15: lc = 8'h71; 8'h2D: lc = 8'h72; 8'h1B: lc = 8'h73; 8'h2C: lc = 8'h74;
            8'h3C: lc = 8'h75; 8'h2A: lc = 8'h76; 8'h1D: lc = 8'h77; 8'h22: lc = 8'h78;
            8'h35: lc = 8'h79; 8'h1A: lc = 8'h7A;
            default: lc = '0;
        endcase
        if (lc != 8'h00) begin
            res = (shift ^ caps) ? (lc - 8'h20) : lc;
        end else begin
            case (code)
                8'h45: res = shift ? 8'h29 : 8'h30;
                8'h16: res = shift ? 8'h21 : 8'h31;
                8'h1E: res = shift ? 8'h40 : 8'h32;
                8'h26: res = shift ? 8'h23 : 8'h33;
                8'h25: res = shift ? 8'h24 : 8'h34;
                8'h2E: res = shift ? 8'h25 : 8'h35;
                8'h36: res = shift ? 8'h5E : 8'h36;
                8'h3D: res = shift ? 8'h26 : 8'h37;
                8'h3E: res = shift ? 8'h2A : 8'h38;
                8'h46: res = shift ? 8'h28 : 8'h39;
                8'h29: res = 8'h20;
                8'h5A: res = 8'h0D;
                8'h66: res = 8'h08;
                default: res = '0;
            endcase
        end
        return res;
    endfunction
`endif

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-input and event-output bundle of the PS/2 scan-code decoder.
// slave = decoder side, master = receiver/application side.
interface ps2_scancode_decoder_if;

    logic       i_frame_done;
    logic [7:0] i_frame_data;
    logic       i_rd_en;
    logic       i_ovf_clr;
    logic       o_empty;
    logic       o_full;
    logic       o_overflow;
    logic [7:0] o_key_code;
    logic       o_key_ext;
    logic       o_key_release;
    logic [7:0] o_ascii;

    modport slave (
        input  i_frame_done, i_frame_data, i_rd_en, i_ovf_clr,
        output o_empty, o_full, o_overflow, o_key_code, o_key_ext, o_key_release, o_ascii
    );

    modport master (
        output i_frame_done, i_frame_data, i_rd_en, i_ovf_clr,
        input  o_empty, o_full, o_overflow, o_key_code, o_key_ext, o_key_release, o_ascii
    );

endinterface

// File: rtl/ps2_key_fifo.sv
// Generic show-ahead synchronous FIFO with sticky overflow flag.
// Pointers carry one extra wrap bit to tell full from empty.
module ps2_key_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 byte stream -> key event FIFO (resync, E0/F0 prefix FSM, prefix timeout).
// Define KB_ASCII_EN to add shift/caps tracking and per-event ASCII translation.
module ps2_scancode_decoder
    import ps2_kb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 2500000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    ps2_scancode_decoder_if.slave kb
);

    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam int unsigned EV_W = $bits(kb_event_t);

    logic [2:0]      done_sync;
    logic            strobe;
    logic [7:0]      b;
    kb_state_e       state_q;
    kb_state_e       state_d;
    logic [TO_W-1:0] to_cnt_q;
    logic            to_hit;
    logic            push_d;
    kb_event_t       ev_d;
    logic            push_q;
    kb_event_t       ev_q;
    logic [EV_W-1:0] head_raw;
    kb_event_t       head;
`ifdef KB_ASCII_EN
    logic            shift_q;
    logic            caps_q;
`endif

    // Bits [1:0] are the synchroniser; bit [2] is the previous level for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            done_sync <= '0;
        end else begin
            done_sync <= {done_sync[1:0], kb.i_frame_done};
        end
    end

    assign strobe = done_sync[1] && !done_sync[2];
    assign b      = kb.i_frame_data;
    assign to_hit = (state_q != ST_IDLE) && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        push_d  = 1'b0;
        ev_d    = '0;
        if (strobe) begin
            if (b == KB_ERR_00 || b == KB_ERR_FF) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (b == KB_PFX_EXT)                 state_d = ST_EXT;
                        else if (b == KB_PFX_BRK)            state_d = ST_BRK;
                        else if (b != KB_BAT_OK && b != KB_ACK) push_d = 1'b1;
                    end
                    ST_EXT: begin
                        if (b == KB_PFX_BRK)      state_d = ST_EXT_BRK;
                        else if (b != KB_PFX_EXT) begin
                            push_d   = 1'b1;
                            ev_d.ext = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        if (b == KB_PFX_EXT)      state_d = ST_EXT_BRK;
                        else if (b != KB_PFX_BRK) begin
                            push_d   = 1'b1;
                            ev_d.rel = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                    default: begin
                        if (b != KB_PFX_EXT && b != KB_PFX_BRK) begin
                            push_d   = 1'b1;
                            ev_d.ext = 1'b1;
                            ev_d.rel = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                endcase
            end
            if (push_d) begin
                ev_d.code = b;
            end
        end else if (to_hit) begin
            state_d = ST_IDLE;
        end
`ifdef KB_ASCII_EN
        if (push_d && !ev_d.ext && !ev_d.rel) begin
            ev_d.ascii = kb_ascii_lookup(b, shift_q, caps_q);
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            to_cnt_q <= '0;
            push_q   <= 1'b0;
            ev_q     <= '0;
        end else begin
            state_q <= state_d;
            push_q  <= push_d;
            ev_q    <= ev_d;
            if (strobe || state_q == ST_IDLE || to_hit) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

`ifdef KB_ASCII_EN
    // Modifier state changes take effect from the next event; the lookup above used the old value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q <= 1'b0;
            caps_q  <= 1'b0;
        end else if (push_d && !ev_d.ext) begin
            if (b == 8'h12 || b == 8'h59) begin
                shift_q <= !ev_d.rel;
            end
            if (b == 8'h58 && !ev_d.rel) begin
                caps_q <= !caps_q;
            end
        end
    end
`endif

    ps2_key_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .push     (push_q),
        .wdata    (ev_q),
        .pop      (kb.i_rd_en),
        .ovf_clr  (kb.i_ovf_clr),
        .rdata    (head_raw),
        .full     (kb.o_full),
        .empty    (kb.o_empty),
        .overflow (kb.o_overflow)
    );

    assign head             = kb_event_t'(head_raw);
    assign kb.o_key_code    = head.code;
    assign kb.o_key_ext     = head.ext;
    assign kb.o_key_release = head.rel;
`ifdef KB_ASCII_EN
    assign kb.o_ascii       = head.ascii;
`else
    assign kb.o_ascii       = 8'h00;
`endif

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumes raw bytes from the PS/2 frame receiver (byte-done flag plus 8-bit byte, both in the PS/2 clock domain).
- Resynchronises them into the system clock domain and decodes Set-2 prefixes (E0 extended, F0 break) into key events.
- Buffers events in a small show-ahead FIFO read by the application logic (display/text buffer).

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, >=2.
- TIMEOUT_CYC, 2500000, i_clk cycles a pending prefix (E0/F0) may wait for its next byte before the FSM returns to IDLE (25 ms at 100 MHz).

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_frame_done  in  1  receiver byte-done level, asynchronous to i_clk, high for at least one PS/2 clock period.
- i_frame_data  in  8  received byte; stable while i_frame_done is high.
- i_rd_en  in  1  pop the head event; ignored when o_empty.
- i_ovf_clr  in  1  clears o_overflow.
- o_empty  out  1  FIFO empty.
- o_full  out  1  FIFO full.
- o_overflow  out  1  sticky; an event was dropped on a full FIFO.
- o_key_code  out  8  head event scan code (valid when !o_empty).
- o_key_ext  out  1  head event carried the E0 prefix.
- o_key_release  out  1  head event is a break (F0).
- o_ascii  out  8  head event ASCII (see Optional Feature).

Behaviour:
- Reset (async, i_rst_n low): FSM IDLE, FIFO empty, timeout counter 0, synchroniser flops 0.
  - Outputs on reset: o_empty=1, o_full=0, o_overflow=0, o_key_*=0, o_ascii=0.
- Input path:
  - i_frame_done passes through a 2-flop synchroniser, then a rising-edge detector.
  - On the detected edge (byte strobe), i_frame_data is sampled in that same cycle.
  - One strobe per byte; a level that stays high produces no repeat.
- Strobe-to-FIFO latency: the event is written 1 cycle after the strobe, and o_empty falls on the next cycle.
- FSM states: IDLE, EXT, BRK, EXT_BRK. On each strobe with byte b:
  - In any state, b=0x00 or 0xFF (keyboard error) -> discard, go to IDLE.
  - IDLE:
    - b=E0 -> EXT.
    - b=F0 -> BRK.
    - b=AA or FA (BAT / ack) -> discard.
    - Any other b -> push {ext=0, rel=0, b}.
  - EXT:
    - b=F0 -> EXT_BRK.
    - b=E0 -> stay in EXT.
    - Any other b -> push {1, 0, b}, go to IDLE.
  - BRK:
    - b=E0 -> EXT_BRK.
    - b=F0 -> stay in BRK.
    - Any other b -> push {0, 1, b}, go to IDLE.
  - EXT_BRK:
    - b=E0 or F0 -> stay in EXT_BRK.
    - Any other b -> push {1, 1, b}, go to IDLE.
- Timeout:
  - The counter runs only while the FSM is not IDLE and clears on every strobe.
  - When it reaches TIMEOUT_CYC-1, the FSM goes to IDLE with no push.
- FIFO:
  - Show-ahead: outputs reflect the head entry whenever !o_empty.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Push while full and no pop: the event is dropped and o_overflow is set.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Push and pop in the same cycle while empty: the pop is ignored and the push succeeds.
  - If i_ovf_clr and a new overflow occur in the same cycle, the set wins.
- Reset mid-sequence (e.g. after E0): the pending prefix is lost and FIFO contents are discarded.

Optional Feature:
- Macro: KB_ASCII_EN.
- With the macro defined:
  - The block tracks shift_held (make/break of non-extended 0x12 or 0x59) and caps_lock (toggles on make of non-extended 0x58).
  - At push time, each event gets an 8-bit ASCII value stored in the FIFO entry.
  - Mapped codes:
    - Letters: case = shift XOR caps.
    - Digits 0-9: the shifted symbol when shift is held.
    - 0x29 -> 0x20, 0x5A -> 0x0D, 0x66 -> 0x08.
  - Extended events, break events and unmapped codes give 0x00.
  - Shift state updates before the ASCII lookup of a later event, never the same event.
- Without the macro: no tracking logic, FIFO entries are 10 bits, o_ascii is tied to 0x00.

Decomposition:
- Package ps2_kb_pkg:
  - Prefix constants E0, F0, AA, FA, 00, FF.
  - FSM state enum.
  - Event entry struct {ext, rel, code[7:0], ascii[7:0] (ifdef)}.
  - ASCII lookup function (ifdef).
- Sub-module ps2_key_fifo: a generic show-ahead synchronous FIFO with width/depth parameters and push/pop/full/empty/overflow.

Test Plan:
- Bytes 1C; F0 1C -> two events {0,0,1C} then {0,1,1C}; with KB_ASCII_EN, o_ascii = 0x61 then 0x00.
- Bytes E0 75; E0 F0 75 -> events {1,0,75} then {1,1,75}; the 00 byte sent between them is discarded and does not disturb the FSM.
- Byte E0, then silence for TIMEOUT_CYC cycles, then 1C -> single event {0,0,1C}.
- 9 make codes pushed with FIFO_DEPTH=8 and no reads -> o_full=1, 9th event dropped, o_overflow=1.
  - Then assert i_rd_en and push in the same cycle -> count stays 8.
  - Then i_ovf_clr -> o_overflow=0.
- KB_ASCII_EN: 12, 1C, F0 12, 58, 1C -> o_ascii = 0x00, 0x41, 0x00, 0x00, 0x41; 0x16 with shift held -> 0x21.
- Bytes AA, FA at power-up then reset asserted after E0 -> no events; o_empty=1; next 1C gives {0,0,1C}.
